// File: rtl/ptag_free_list.sv
// ptag_free_list: circular free list of physical tags with speculative/committed heads,
// one-cycle flush recovery and a post-reset self-initialisation sweep.
module ptag_free_list #(
    parameter int NUM_PTAGS  = 64,
    parameter int NUM_ARCH   = 32,
    parameter int PTAG_WIDTH = $clog2(NUM_PTAGS),
    localparam int DEPTH     = NUM_PTAGS - NUM_ARCH,
    localparam int PTR_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_valid,
    output logic [PTAG_WIDTH-1:0] alloc_ptag,
    input  logic                  commit_valid,
    input  logic [PTAG_WIDTH-1:0] commit_ptag,
    input  logic                  flush,
    output logic [PTR_W-1:0]      free_count,
    output logic                  init_done
);
    localparam int IW = PTR_W - 1;

    typedef enum logic {INIT, READY} state_t;

    state_t                state, state_n;
    logic [IW-1:0]         init_idx;
    logic [PTR_W-1:0]      spec_head, commit_head, tail, commit_head_n, cnt;
    logic [PTAG_WIDTH-1:0] mem [DEPTH];
    logic                  ready, alloc_fire, commit_fire;

    always_comb begin
        state_n = state;
        if (state == INIT && init_idx == IW'(DEPTH - 1)) state_n = READY;
    end

    always_ff @(posedge clk) state <= rst ? INIT : state_n;

    assign ready         = state == READY;
    assign cnt           = tail - spec_head;
    assign free_count    = ready ? cnt : '0;
    assign alloc_valid   = ready && cnt != '0;
    assign alloc_ptag    = alloc_valid ? mem[spec_head[IW-1:0]] : '0;
    assign init_done     = ready;
    assign alloc_fire    = alloc_req && alloc_valid && !flush;
    assign commit_fire   = ready && commit_valid;
    // Flush recovers to the committed head including this cycle's commit.
    assign commit_head_n = commit_head + PTR_W'(commit_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx    <= '0;
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= PTR_W'(DEPTH);
        end else if (!ready) begin
            init_idx <= init_idx + IW'(1);
        end else begin
            commit_head <= commit_head_n;
            tail        <= tail + PTR_W'(commit_fire);
            spec_head   <= flush ? commit_head_n : spec_head + PTR_W'(alloc_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !ready)
            mem[init_idx] <= PTAG_WIDTH'(NUM_ARCH) + PTAG_WIDTH'(init_idx);
        else if (!rst && commit_fire)
            mem[tail[IW-1:0]] <= commit_ptag;
    end

    a_commit_nothing_allocated: assert property (@(posedge clk) disable iff (rst)
        commit_fire |-> commit_head != spec_head);
    a_alloc_when_empty: assert property (@(posedge clk) disable iff (rst)
        alloc_fire |-> free_count != '0);
endmodule

// File: tb/tb_ptag_free_list.sv
// tb_ptag_free_list: directed and random stimulus against a queue-based model of the free list.
module tb_ptag_free_list;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst, alloc_req, alloc_valid, commit_valid, flush, init_done;
    logic [5:0] alloc_ptag, commit_ptag, free_count;

    int checks = 0, errors = 0;
    int q[$];
    int n_spec = 0, init_cnt = 0;
    bit ready = 0, mv = 0;

    ptag_free_list dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
        .alloc_ptag(alloc_ptag), .commit_valid(commit_valid), .commit_ptag(commit_ptag),
        .flush(flush), .free_count(free_count), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Model: q holds the DEPTH tags from the committed head onward in the order
    // they will be handed out; n_spec counts speculative grants not yet committed.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            mv = 1; ready = 0; init_cnt = 0; n_spec = 0;
            q.delete();
            for (int i = 0; i < DEPTH; i++) q.push_back(32 + i);
        end else if (mv && !ready) begin
            init_cnt++;
            if (init_cnt == DEPTH) ready = 1;
        end else if (mv) begin
            automatic bit fire = alloc_req && n_spec < DEPTH && !flush;
            if (commit_valid) begin
                void'(q.pop_front());
                q.push_back(int'(commit_ptag));
                n_spec--;
            end
            if (fire) n_spec++;
            if (flush) n_spec = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mv) begin
            automatic bit ev = ready && n_spec < DEPTH;
            chk("alloc_valid", int'(alloc_valid), int'(ev));
            chk("alloc_ptag", int'(alloc_ptag), ev ? q[n_spec] : 0);
            chk("free_count", int'(free_count), ready ? DEPTH - n_spec : 0);
            chk("init_done", int'(init_done), int'(ready));
        end
    end

    task automatic drive(input bit a, input bit c, input int t, input bit f);
        alloc_req = a; commit_valid = c; commit_ptag = 6'(t); flush = f;
        @(negedge clk);
    endtask

    task automatic reinit();
        rst = 1;
        drive(0, 0, 0, 0);
        rst = 0;
        repeat (DEPTH) drive(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; alloc_req = 0; commit_valid = 0; commit_ptag = 0; flush = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (DEPTH - 1) drive(0, 0, 0, 0);
        chk("init_early_done", int'(init_done), 0);
        drive(0, 0, 0, 0);
        chk("init_done_lit", int'(init_done), 1);
        chk("first_ptag_lit", int'(alloc_ptag), 32);
        chk("first_count_lit", int'(free_count), 32);
        for (int i = 0; i < DEPTH; i++) begin
            chk("grant_lit", int'(alloc_ptag), 32 + i);
            drive(1, 0, 0, 0);
        end
        chk("empty_valid_lit", int'(alloc_valid), 0);
        chk("empty_count_lit", int'(free_count), 0);
        chk("empty_ptag_lit", int'(alloc_ptag), 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 7 + i, 0);
        chk("refill_count_lit", int'(free_count), 5);
        for (int i = 0; i < 5; i++) begin
            chk("refill_grant_lit", int'(alloc_ptag), 7 + i);
            drive(1, 0, 0, 0);
        end
        chk("same_cycle_novalid_lit", int'(alloc_valid), 0);
        drive(1, 1, 9, 0);
        chk("same_cycle_tag_lit", int'(alloc_ptag), 9);
        chk("same_cycle_count_lit", int'(free_count), 1);
        drive(1, 0, 0, 0);
        reinit();
        for (int i = 0; i < 10; i++) begin
            chk("pre_flush_grant_lit", int'(alloc_ptag), 32 + i);
            drive(1, 0, 0, 0);
        end
        for (int i = 1; i <= 3; i++) drive(0, 1, i, 0);
        drive(0, 0, 0, 1);
        chk("flush_ptag_lit", int'(alloc_ptag), 35);
        chk("flush_count_lit", int'(free_count), 32);
        for (int i = 0; i < 28; i++) begin
            chk("post_flush_grant_lit", int'(alloc_ptag), 35 + i);
            drive(1, 0, 0, 0);
        end
        chk("count4_lit", int'(free_count), 4);
        drive(1, 1, 20, 0);
        chk("count4_hold_lit", int'(free_count), 4);
        for (int i = 1; i <= 3; i++) begin
            chk("wrap_grant_lit", int'(alloc_ptag), i);
            drive(1, 0, 0, 0);
        end
        chk("wrap_tail_lit", int'(alloc_ptag), 20);
        for (int k = 0; k < 3000; k++) begin
            automatic bit c = ready && n_spec > 0 && $urandom_range(0, 1) == 1;
            drive($urandom_range(0, 1) == 1, c, $urandom_range(0, 63), $urandom_range(0, 40) == 0);
        end
        reinit();
        for (int i = 0; i < 19; i++) drive(1, 0, 0, 0);
        rst = 1;
        drive(1, 0, 0, 0);
        chk("rst_mid_valid_lit", int'(alloc_valid), 0);
        chk("rst_mid_ptag_lit", int'(alloc_ptag), 0);
        chk("rst_mid_count_lit", int'(free_count), 0);
        chk("rst_mid_done_lit", int'(init_done), 0);
        rst = 0;
        repeat (DEPTH) drive(0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("regrant_lit", int'(alloc_ptag), 32 + i);
            drive(1, 0, 0, 0);
        end
        drive(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
